// File: rtl/settings_controller.sv
// Button-driven editor for volume/octave/loop_width with mode select, auto-repeat and saturation.
// Latency: one clk from button edge to registered outputs; no combinational input-to-output path.
// Backpressure: none; buttons are sampled every cycle and consumers read levels plus a changed pulse.
module settings_controller #(
    parameter int VOL_MIN       = 1,
    parameter int VOL_MAX       = 5,
    parameter int VOL_INIT      = 3,
    parameter int OCT_MIN       = 3,
    parameter int OCT_MAX       = 5,
    parameter int OCT_INIT      = 4,
    parameter int LOOP_MIN      = 1,
    parameter int LOOP_MAX      = 7,
    parameter int LOOP_INIT     = 4,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_mode,
    output logic [2:0] volume,
    output logic [2:0] octave,
    output logic [2:0] loop_width,
    output logic [1:0] sel,
    output logic       changed
);

    localparam int MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    localparam logic [2:0] V_MIN = 3'(VOL_MIN);
    localparam logic [2:0] V_MAX = 3'(VOL_MAX);
    localparam logic [2:0] O_MIN = 3'(OCT_MIN);
    localparam logic [2:0] O_MAX = 3'(OCT_MAX);
    localparam logic [2:0] L_MIN = 3'(LOOP_MIN);
    localparam logic [2:0] L_MAX = 3'(LOOP_MAX);

    typedef enum logic [1:0] {
        SEL_VOL  = 2'd0,
        SEL_OCT  = 2'd1,
        SEL_LOOP = 2'd2
    } sel_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_HOLD   = 2'd1,
        PH_REPEAT = 2'd2
    } phase_t;

    sel_t          sel_q;
    phase_t        phase;
    logic [CW-1:0] rep_cnt;
    logic          hold_dir_up;
    logic          up_prev;
    logic          down_prev;
    logic          mode_prev;

    logic          press_up;
    logic          press_down;
    logic          press_mode;
    logic          both_held;
    logic          held_btn;
    logic          step_req;
    logic          step_inc;
    logic          sel_valid;
    logic [2:0]    cur_val;
    logic [2:0]    lo_val;
    logic [2:0]    hi_val;
    logic [2:0]    nxt_val;
    logic          do_write;

    assign press_up   = btn_up   & ~up_prev;
    assign press_down = btn_down & ~down_prev;
    assign press_mode = btn_mode & ~mode_prev;
    assign both_held  = btn_up & btn_down;
    assign held_btn   = hold_dir_up ? btn_up : btn_down;
    assign sel        = sel_q;

    // A step comes either from a fresh single press or from the repeat timer expiring.
    always_comb begin
        step_req = 1'b0;
        step_inc = 1'b0;
        if (!press_mode && !both_held) begin
            if (press_up || press_down) begin
                step_req = 1'b1;
                step_inc = press_up;
            end else if (held_btn &&
                         ((phase == PH_HOLD   && rep_cnt == HOLD_LAST) ||
                          (phase == PH_REPEAT && rep_cnt == REP_LAST))) begin
                step_req = 1'b1;
                step_inc = hold_dir_up;
            end
        end
    end

    always_comb begin
        cur_val   = 3'd0;
        lo_val    = 3'd0;
        hi_val    = 3'd0;
        sel_valid = 1'b1;
        case (sel_q)
            SEL_VOL: begin
                cur_val = volume;
                lo_val  = V_MIN;
                hi_val  = V_MAX;
            end
            SEL_OCT: begin
                cur_val = octave;
                lo_val  = O_MIN;
                hi_val  = O_MAX;
            end
            SEL_LOOP: begin
                cur_val = loop_width;
                lo_val  = L_MIN;
                hi_val  = L_MAX;
            end
            default: sel_valid = 1'b0;
        endcase
    end

    always_comb begin
        nxt_val = cur_val;
        if (step_inc) begin
            if (cur_val < hi_val) nxt_val = cur_val + 3'd1;
        end else begin
            if (cur_val > lo_val) nxt_val = cur_val - 3'd1;
        end
    end

    // Saturated steps leave the value untouched and therefore never raise changed.
    assign do_write = step_req & sel_valid & (nxt_val != cur_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            volume      <= 3'(VOL_INIT);
            octave      <= 3'(OCT_INIT);
            loop_width  <= 3'(LOOP_INIT);
            sel_q       <= SEL_VOL;
            changed     <= 1'b0;
            up_prev     <= 1'b0;
            down_prev   <= 1'b0;
            mode_prev   <= 1'b0;
            phase       <= PH_IDLE;
            rep_cnt     <= '0;
            hold_dir_up <= 1'b0;
        end else begin
            up_prev   <= btn_up;
            down_prev <= btn_down;
            mode_prev <= btn_mode;
            changed   <= do_write;

            if (do_write) begin
                case (sel_q)
                    SEL_VOL:  volume     <= nxt_val;
                    SEL_OCT:  octave     <= nxt_val;
                    SEL_LOOP: loop_width <= nxt_val;
                    default:  ;
                endcase
            end

            case (sel_q)
                SEL_VOL:  if (press_mode) sel_q <= SEL_OCT;
                SEL_OCT:  if (press_mode) sel_q <= SEL_LOOP;
                SEL_LOOP: if (press_mode) sel_q <= SEL_VOL;
                default:  sel_q <= SEL_VOL;
            endcase

            if (press_mode || both_held) begin
                phase   <= PH_IDLE;
                rep_cnt <= '0;
            end else if (press_up || press_down) begin
                phase       <= PH_HOLD;
                rep_cnt     <= '0;
                hold_dir_up <= press_up;
            end else begin
                case (phase)
                    PH_HOLD: begin
                        if (!held_btn) begin
                            phase   <= PH_IDLE;
                            rep_cnt <= '0;
                        end else if (rep_cnt == HOLD_LAST) begin
                            phase   <= PH_REPEAT;
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    PH_REPEAT: begin
                        if (!held_btn) begin
                            phase   <= PH_IDLE;
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        phase   <= PH_IDLE;
                        rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_settings_controller.sv
// Directed and random stimulus for settings_controller, checked against a press/hold-time model.
module tb_settings_controller;

    localparam int HOLD = 4;
    localparam int REP  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_mode;
    logic [2:0] volume;
    logic [2:0] octave;
    logic [2:0] loop_width;
    logic [1:0] sel;
    logic       changed;

    always #5 clk = ~clk;

    settings_controller #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_mode   (btn_mode),
        .volume     (volume),
        .octave     (octave),
        .loop_width (loop_width),
        .sel        (sel),
        .changed    (changed)
    );

    int total = 0;
    int bad   = 0;

    // Model: values indexed by selection, plus "cycles held since the press" for auto-repeat.
    int mn[3]   = '{1, 3, 1};
    int mx[3]   = '{5, 5, 7};
    int init[3] = '{3, 4, 4};
    int mval[3];
    int msel;
    bit mchg;
    bit pu_p, pd_p, pm_p;
    bit active, dir_up;
    int held;
    int chg_cnt;

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) mval[i] = init[i];
        msel   = 0;
        mchg   = 0;
        pu_p   = 0;
        pd_p   = 0;
        pm_p   = 0;
        active = 0;
        dir_up = 0;
        held   = 0;
    endfunction

    function automatic void m_step(bit inc);
        int nv;
        nv = inc ? mval[msel] + 1 : mval[msel] - 1;
        if (nv > mx[msel]) nv = mx[msel];
        if (nv < mn[msel]) nv = mn[msel];
        mchg = (nv != mval[msel]);
        mval[msel] = nv;
    endfunction

    function automatic void m_clock(bit u, bit d, bit m);
        bit pu, pd, pm;
        pu   = u & ~pu_p;
        pd   = d & ~pd_p;
        pm   = m & ~pm_p;
        mchg = 0;
        if (pm) begin
            msel   = (msel + 1) % 3;
            active = 0;
        end else if (u && d) begin
            active = 0;
        end else if (pu || pd) begin
            dir_up = pu;
            active = 1;
            held   = 0;
            m_step(pu);
        end else if (active) begin
            if (dir_up ? u : d) begin
                held++;
                if (held == HOLD || (held > HOLD && (held - HOLD) % REP == 0))
                    m_step(dir_up);
            end else begin
                active = 0;
            end
        end
        pu_p = u;
        pd_p = d;
        pm_p = m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".volume"},     32'(volume),     32'(mval[0]));
        check({tag, ".octave"},     32'(octave),     32'(mval[1]));
        check({tag, ".loop_width"}, 32'(loop_width), 32'(mval[2]));
        check({tag, ".sel"},        32'(sel),        32'(msel));
        check({tag, ".changed"},    32'(changed),    32'(mchg));
    endtask

    task automatic cyc(input string tag, input bit u, input bit d, input bit m);
        btn_up   = u;
        btn_down = d;
        btn_mode = m;
        @(posedge clk);
        m_clock(u, d, m);
        #1;
        if (changed === 1'b1) chg_cnt++;
        check_all(tag);
    endtask

    initial begin
        bit ru, rd, rm;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_mode = 1'b0;
        chg_cnt  = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Saturation on volume: 3 -> 4,5,5,5 then down to 1.
        chg_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("sat_up", 1, 0, 0);
            cyc("sat_up_rel", 0, 0, 0);
        end
        check("sat_vol_max", 32'(volume), 32'd5);
        check("sat_chg_cnt", 32'(chg_cnt), 32'd2);
        for (int i = 0; i < 6; i++) begin
            cyc("sat_dn", 0, 1, 0);
            cyc("sat_dn_rel", 0, 0, 0);
        end
        check("sat_vol_min", 32'(volume), 32'd1);

        // Mode cycling, edit octave, then mode+up in the same cycle.
        for (int i = 0; i < 3; i++) begin
            cyc("mode", 0, 0, 1);
            cyc("mode_rel", 0, 0, 0);
        end
        check("mode_wrap", 32'(sel), 32'd0);
        cyc("mode_oct", 0, 0, 1);
        cyc("mode_oct_rel", 0, 0, 0);
        cyc("oct_up", 1, 0, 0);
        check("oct_up_val", 32'(octave), 32'd5);
        cyc("oct_up_rel", 0, 0, 0);
        cyc("mode_and_up", 1, 0, 1);
        check("mode_and_up_sel", 32'(sel), 32'd2);
        check("mode_and_up_chg", 32'(changed), 32'd0);
        cyc("mode_and_up_rel", 0, 0, 0);

        // Bring loop_width to 1, then hold up for auto-repeat.
        for (int i = 0; i < 4; i++) begin
            cyc("loop_dn", 0, 1, 0);
            cyc("loop_dn_rel", 0, 0, 0);
        end
        check("loop_at_min", 32'(loop_width), 32'd1);
        cyc("hold_up_press", 1, 0, 0);
        check("hold_press_val", 32'(loop_width), 32'd2);
        for (int i = 1; i < 12; i++) begin
            cyc("hold_up", 1, 0, 0);
            if (i == 4) check("hold_first_rep", 32'(loop_width), 32'd3);
        end
        for (int i = 0; i < 6; i++) cyc("hold_release", 0, 0, 0);

        // Simultaneous up and down, then drop down without a new up edge.
        for (int i = 0; i < 10; i++) cyc("both", 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc("drop_down", 1, 0, 0);
        cyc("both_rel", 0, 0, 0);

        // Abort a hold by pressing mode while down stays high.
        cyc("abort_press", 0, 1, 0);
        cyc("abort_hold", 0, 1, 0);
        cyc("abort_mode", 0, 1, 1);
        for (int i = 0; i < 10; i++) cyc("abort_after", 0, 1, 0);
        cyc("abort_rel", 0, 0, 0);

        // Asynchronous reset with btn_up held, then the first edge counts as a press.
        btn_up = 1'b1;
        rst    = 1'b1;
        #1;
        m_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b0;
        cyc("rst_release_press", 1, 0, 0);
        check("rst_release_vol", 32'(volume), 32'd4);
        check("rst_release_chg", 32'(changed), 32'd1);
        cyc("rst_release_hold", 1, 0, 0);
        cyc("rst_release_rel", 0, 0, 0);

        // Random button activity with sticky levels so holds and repeats occur.
        ru = 0;
        rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) ru = ~ru;
            if ($urandom_range(0, 13) == 0) rd = ~rd;
            rm = ($urandom_range(0, 11) == 0);
            cyc("random", ru, rd, rm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
